// File: rtl/pc_sequencer.sv
// MIPS fetch PC owner and run-mode sequencer (IDLE/RUN/STEP/DRAIN/HALTED); PC_SEQ_CYCLE_COUNTER_EN adds o_cycle_count.
// Latency: PC updates one clock after an active cycle; o_pipe_en, o_if_flush, o_pc_plus4 are combinational.
// Backpressure: i_stall holds the PC; o_pipe_en low freezes the whole pipeline outside active cycles.
module pc_sequencer #(
    parameter int             LEN          = 32,
    parameter logic [LEN-1:0] RESET_PC     = '0,
    parameter int             DRAIN_CYCLES = 4,
    parameter int             CNT_LEN      = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_continuous,
    input  logic               i_step,
    input  logic               i_clear,
    input  logic               i_stall,
    input  logic               i_branch_taken,
    input  logic [LEN-1:0]     i_branch_target,
    input  logic               i_jump,
    input  logic [LEN-1:0]     i_jump_target,
    input  logic               i_halt_instr,
    output logic [LEN-1:0]     o_pc,
    output logic [LEN-1:0]     o_pc_plus4,
    output logic               o_pipe_en,
    output logic               o_if_flush,
    output logic               o_halted,
    output logic [2:0]         o_state,
    output logic [CNT_LEN-1:0] o_cycle_count
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_STEP   = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_HALTED = 3'd4
    } state_t;

    state_t          state;
    logic [LEN-1:0]  pc;
    logic [DW-1:0]   drain_cnt;
    logic            fetch_active;
    logic            active;
    logic            redirect;

    // Fetch cycles are the ones where the next-PC mux is allowed to act.
    assign fetch_active = (state == ST_RUN) || ((state == ST_STEP) && i_step);
    assign active       = fetch_active || (state == ST_DRAIN);
    assign redirect     = fetch_active && (i_branch_taken || i_jump);

    assign o_pc       = pc;
    assign o_pc_plus4 = pc + LEN'(4);
    assign o_pipe_en  = active;
    assign o_if_flush = redirect;
    assign o_halted   = (state == ST_HALTED);
    assign o_state    = state;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            drain_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state <= i_continuous ? ST_RUN : ST_STEP;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (fetch_active) begin
                        // Redirects squash a HALT sitting in IF, so they win over it.
                        if (i_branch_taken) begin
                            pc <= i_branch_target;
                        end else if (i_jump) begin
                            pc <= i_jump_target;
                        end else if (i_halt_instr) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DW'(DRAIN_CYCLES - 1);
                        end else if (!i_stall) begin
                            pc <= o_pc_plus4;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_HALTED;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                ST_HALTED: begin
                    if (i_clear) begin
                        state <= ST_IDLE;
                        pc    <= RESET_PC;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef PC_SEQ_CYCLE_COUNTER_EN
    logic [CNT_LEN-1:0] cycle_cnt;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cycle_cnt <= '0;
        end else if ((state == ST_HALTED) && i_clear) begin
            cycle_cnt <= '0;
        end else if (active) begin
            cycle_cnt <= cycle_cnt + CNT_LEN'(1);
        end
    end

    assign o_cycle_count = cycle_cnt;
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, hand-written corner sequences, randomized run against a reference model.
module tb_pc_sequencer;

    logic        i_clk;
    logic        i_rst;
    logic        i_start, i_continuous, i_step, i_clear, i_stall;
    logic        i_branch_taken, i_jump, i_halt_instr;
    logic [31:0] i_branch_target, i_jump_target;
    logic [31:0] o_pc, o_pc_plus4, o_cycle_count;
    logic        o_pipe_en, o_if_flush, o_halted;
    logic [2:0]  o_state;

    pc_sequencer dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_start(i_start), .i_continuous(i_continuous), .i_step(i_step), .i_clear(i_clear),
        .i_stall(i_stall), .i_branch_taken(i_branch_taken), .i_branch_target(i_branch_target),
        .i_jump(i_jump), .i_jump_target(i_jump_target), .i_halt_instr(i_halt_instr),
        .o_pc(o_pc), .o_pc_plus4(o_pc_plus4), .o_pipe_en(o_pipe_en), .o_if_flush(o_if_flush),
        .o_halted(o_halted), .o_state(o_state), .o_cycle_count(o_cycle_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        i_start = 0; i_continuous = 0; i_step = 0; i_clear = 0; i_stall = 0;
        i_branch_taken = 0; i_jump = 0; i_halt_instr = 0;
        i_branch_target = '0; i_jump_target = '0;
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- reference model (modes numbered as in the debug readback) ----------------
    int          m_mode;
    logic [31:0] m_pc;
    int          m_drain_left;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_mode = 0; m_pc = 32'h0; m_drain_left = 0; m_cnt = 32'h0;
    endtask

    function automatic bit m_fetch();
        return (m_mode == 1) || (m_mode == 2 && i_step);
    endfunction

    function automatic bit m_en();
        return m_fetch() || (m_mode == 3);
    endfunction

    task automatic model_step();
        bit fetch;
        fetch = m_fetch();
`ifdef PC_SEQ_CYCLE_COUNTER_EN
        if (m_en()) m_cnt = m_cnt + 1;
`endif
        case (m_mode)
            0: if (i_start) m_mode = i_continuous ? 1 : 2;
            1, 2: if (fetch) begin
                if (i_branch_taken)    m_pc = i_branch_target;
                else if (i_jump)       m_pc = i_jump_target;
                else if (i_halt_instr) begin m_mode = 3; m_drain_left = 4; end
                else if (!i_stall)     m_pc = m_pc + 32'd4;
            end
            3: begin
                m_drain_left = m_drain_left - 1;
                if (m_drain_left == 0) m_mode = 4;
            end
            4: if (i_clear) begin m_mode = 0; m_pc = 32'h0; m_cnt = 32'h0; end
            default: ;
        endcase
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0]  ctl;   // {start, cont, step, clear, stall, br, jmp, halt}
        logic [31:0] bt;
        logic [31:0] jt;
        logic        en;
        logic        fl;
        logic [31:0] pc;    // PC after the edge
        logic [2:0]  st;    // state after the edge
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] ctl, input logic [31:0] bt, input logic [31:0] jt,
                                input logic en, input logic fl, input logic [31:0] pc, input logic [2:0] st);
        vec_t v;
        v.ctl = ctl; v.bt = bt; v.jt = jt; v.en = en; v.fl = fl; v.pc = pc; v.st = st;
        return v;
    endfunction

    task automatic do_reset();
        clr_in();
        i_rst = 0;
        #3;
        chk("rst_state", o_state, 3'd0);
        chk("rst_pc", o_pc, 32'h0);
        chk("rst_pipe_en", o_pipe_en, 1'b0);
        chk("rst_flush", o_if_flush, 1'b0);
        chk("rst_halted", o_halted, 1'b0);
        chk("rst_count", o_cycle_count, 32'h0);
        cyc();
        i_rst = 1;
        model_reset();
    endtask

    logic [31:0] exp_cnt;

    initial begin
        clr_in();
        i_rst = 1;
        #2;
        do_reset();

        tbl.push_back(mk(8'b1100_0000, 0, 0, 0, 0, 32'h0, 3'd1));
        tbl.push_back(mk(8'b0000_0000, 0, 0, 1, 0, 32'h4, 3'd1));
        tbl.push_back(mk(8'b0000_0000, 0, 0, 1, 0, 32'h8, 3'd1));
        tbl.push_back(mk(8'b0000_0000, 0, 0, 1, 0, 32'hC, 3'd1));
        tbl.push_back(mk(8'b0000_0000, 0, 0, 1, 0, 32'h10, 3'd1));
        tbl.push_back(mk(8'b0000_1100, 32'h40, 0, 1, 1, 32'h40, 3'd1));   // branch beats stall
        tbl.push_back(mk(8'b0000_0010, 0, 32'h80, 1, 1, 32'h80, 3'd1));
        tbl.push_back(mk(8'b0000_0011, 0, 32'h100, 1, 1, 32'h100, 3'd1)); // jump squashes halt
        tbl.push_back(mk(8'b0000_0000, 0, 0, 1, 0, 32'h104, 3'd1));
        tbl.push_back(mk(8'b0000_0001, 0, 0, 1, 0, 32'h104, 3'd3));
        tbl.push_back(mk(8'b1010_1100, 32'h200, 0, 1, 0, 32'h104, 3'd3)); // drain ignores redirects
        tbl.push_back(mk(8'b0000_0000, 0, 0, 1, 0, 32'h104, 3'd3));
        tbl.push_back(mk(8'b0000_0000, 0, 0, 1, 0, 32'h104, 3'd3));
        tbl.push_back(mk(8'b0000_0000, 0, 0, 1, 0, 32'h104, 3'd4));
        tbl.push_back(mk(8'b1010_0110, 32'h300, 32'h400, 0, 0, 32'h104, 3'd4));
        tbl.push_back(mk(8'b0001_0000, 0, 0, 0, 0, 32'h0, 3'd0));
        tbl.push_back(mk(8'b0011_0000, 0, 0, 0, 0, 32'h0, 3'd0));
        tbl.push_back(mk(8'b1000_0000, 0, 0, 0, 0, 32'h0, 3'd2));
        tbl.push_back(mk(8'b0000_0101, 32'h40, 0, 0, 0, 32'h0, 3'd2));    // no step: ignored
        tbl.push_back(mk(8'b0010_0000, 0, 0, 1, 0, 32'h4, 3'd2));
        tbl.push_back(mk(8'b0010_1000, 0, 0, 1, 0, 32'h4, 3'd2));
        tbl.push_back(mk(8'b0000_0000, 0, 0, 0, 0, 32'h4, 3'd2));
        tbl.push_back(mk(8'b0010_0001, 0, 0, 1, 0, 32'h4, 3'd3));

        foreach (tbl[k]) begin
            {i_start, i_continuous, i_step, i_clear, i_stall, i_branch_taken, i_jump, i_halt_instr} = tbl[k].ctl;
            i_branch_target = tbl[k].bt;
            i_jump_target   = tbl[k].jt;
            #2;
            chk($sformatf("vec%0d_pipe_en", k), o_pipe_en, tbl[k].en);
            chk($sformatf("vec%0d_flush", k), o_if_flush, tbl[k].fl);
            chk($sformatf("vec%0d_plus4", k), o_pc_plus4, o_pc + 32'd4);
            cyc();
            clr_in();
            chk($sformatf("vec%0d_pc", k), o_pc, tbl[k].pc);
            chk($sformatf("vec%0d_state", k), o_state, tbl[k].st);
            chk($sformatf("vec%0d_halted", k), o_halted, tbl[k].st == 3'd4);
        end

        // PC wrap at the top of the address space
        do_reset();
        i_start = 1; i_continuous = 1; cyc(); clr_in();
        i_jump = 1; i_jump_target = 32'hFFFF_FFF8; cyc(); clr_in();
        #2;
        chk("wrap_pc_f8", o_pc, 32'hFFFF_FFF8);
        cyc();
        chk("wrap_pc_fc", o_pc, 32'hFFFF_FFFC);
        chk("wrap_plus4", o_pc_plus4, 32'h0);
        cyc();
        chk("wrap_pc_0", o_pc, 32'h0);

        // Async reset in the second drain cycle
        i_halt_instr = 1; cyc(); clr_in();
        cyc();
        #2;
        chk("mid_drain_state", o_state, 3'd3);
        chk("mid_drain_pipe_en", o_pipe_en, 1'b1);
        i_rst = 0;
        #1;
        chk("async_rst_state", o_state, 3'd0);
        chk("async_rst_pc", o_pc, 32'h0);
        chk("async_rst_pipe_en", o_pipe_en, 1'b0);
        cyc();
        i_rst = 1;

        // 10 RUN cycles (last fetches HALT) plus 4 drain cycles
        do_reset();
        i_start = 1; i_continuous = 1; cyc(); clr_in();
        for (int c = 0; c < 9; c++) cyc();
        chk("cnt_run_pc", o_pc, 32'd36);
        i_halt_instr = 1; cyc(); clr_in();
        for (int c = 0; c < 4; c++) cyc();
`ifdef PC_SEQ_CYCLE_COUNTER_EN
        exp_cnt = 32'd14;
`else
        exp_cnt = 32'd0;
`endif
        chk("cnt_halted_state", o_state, 3'd4);
        chk("cnt_halted_value", o_cycle_count, exp_cnt);
        chk("cnt_halted_pc", o_pc, 32'd36);
        i_clear = 1; cyc(); clr_in();
        chk("cnt_after_clear", o_cycle_count, 32'h0);
        chk("clear_state", o_state, 3'd0);

        // Randomized run against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            i_start         = ($urandom_range(0, 99) < 20);
            i_continuous    = ($urandom_range(0, 99) < 50);
            i_step          = ($urandom_range(0, 99) < 40);
            i_clear         = ($urandom_range(0, 99) < 15);
            i_stall         = ($urandom_range(0, 99) < 20);
            i_branch_taken  = ($urandom_range(0, 99) < 10);
            i_jump          = ($urandom_range(0, 99) < 10);
            i_halt_instr    = ($urandom_range(0, 99) < 5);
            i_branch_target = $urandom & 32'hFFFF_FFFC;
            i_jump_target   = $urandom & 32'hFFFF_FFFC;
            #2;
            chk("rnd_pc", o_pc, m_pc);
            chk("rnd_plus4", o_pc_plus4, m_pc + 32'd4);
            chk("rnd_state", o_state, m_mode[2:0]);
            chk("rnd_halted", o_halted, m_mode == 4);
            chk("rnd_pipe_en", o_pipe_en, m_en());
            chk("rnd_flush", o_if_flush, m_fetch() && (i_branch_taken || i_jump));
            chk("rnd_count", o_cycle_count, m_cnt);
            model_step();
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the MIPS fetch program counter and sequences its updates for the pipeline and the debug unit.
- Selects the next PC from these sources: sequential (PC+4), branch target, jump target, or hold on stall.
- Provides run-mode control: continuous run, single-step, halt-instruction drain, halted.
- Sits between the debug UART controller and the IF stage. Drives instruction-memory address and the pipeline-wide enable.

Parameters:
- LEN, 32, PC / target width in bits
- RESET_PC, 0, PC value after reset and after i_clear
- DRAIN_CYCLES, 4, cycles to keep pipeline enabled after HALT fetch (IF..WB drain)
- CNT_LEN, 32, cycle counter width

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle pulse; leave IDLE
- i_continuous  in  1  sampled with i_start: 1 = RUN, 0 = STEP
- i_step  in  1  one-cycle pulse; advance one cycle in STEP mode
- i_clear  in  1  one-cycle pulse; HALTED -> IDLE, PC -> RESET_PC
- i_stall  in  1  load-use hazard; hold PC
- i_branch_taken  in  1  branch resolved taken (ID stage)
- i_branch_target  in  LEN  branch destination
- i_jump  in  1  jump decoded (ID stage)
- i_jump_target  in  LEN  jump destination
- i_halt_instr  in  1  HALT opcode present in IF
- o_pc  out  LEN  current PC (instruction-memory address)
- o_pc_plus4  out  LEN  o_pc + 4, combinational
- o_pipe_en  out  1  global pipeline register enable this cycle
- o_if_flush  out  1  squash IF/ID this cycle (redirect taken)
- o_halted  out  1  state == HALTED
- o_state  out  3  encoded state for debug readback
- o_cycle_count  out  CNT_LEN  see Optional Feature

Behaviour:
- Reset (async, i_rst low) puts the block in this condition:
  - State IDLE, o_pc = RESET_PC, drain counter 0.
  - o_pipe_en = 0, o_if_flush = 0, o_halted = 0, o_cycle_count = 0.
- State encoding: IDLE = 0, RUN = 1, STEP = 2, DRAIN = 3, HALTED = 4.
- "Active cycle" means any of:
  - RUN, or
  - STEP with i_step = 1, or
  - DRAIN.
- o_pipe_en = 1 exactly on active cycles. It is combinational from state and i_step.
- Next-PC selection applies on active cycles in RUN or STEP. First match wins:
  1. i_branch_taken -> i_branch_target, o_if_flush = 1.
  2. i_jump -> i_jump_target, o_if_flush = 1.
  3. i_halt_instr -> hold PC, go to DRAIN.
  4. i_stall -> hold PC.
  5. Otherwise -> o_pc + 4, modulo 2^LEN (0xFFFFFFFC wraps to 0).
- A redirect (branch or jump) overrides a simultaneous i_halt_instr. The HALT is squashed in IF, so there is no DRAIN entry.
- o_if_flush is 0 outside active RUN/STEP cycles.
- PC never changes on inactive cycles, or in IDLE, DRAIN or HALTED.
- Transitions:
  - IDLE: on i_start, go to RUN if i_continuous = 1, else STEP. i_step and i_clear are ignored.
  - RUN: go to DRAIN on an unredirected i_halt_instr. i_start, i_step and i_clear are ignored.
  - STEP: each i_step pulse is one active cycle, then wait. An unredirected i_halt_instr on an active step goes to DRAIN. Without i_step, i_halt_instr is ignored.
  - DRAIN:
    - Load the counter with DRAIN_CYCLES - 1 on entry.
    - Decrement each cycle. o_pipe_en = 1 for exactly DRAIN_CYCLES cycles, independent of mode and i_step.
    - Go to HALTED when the counter is 0.
    - Branch, jump and stall inputs are ignored.
  - HALTED: o_pipe_en = 0, o_halted = 1. On i_clear, go to IDLE with o_pc = RESET_PC. All other inputs are ignored.
- Async reset from any state, mid-drain included, returns immediately to the reset condition.

Optional Feature:
- Macro: PC_SEQ_CYCLE_COUNTER_EN.
- Defined:
  - o_cycle_count increments by 1 on every active cycle, wrapping at 2^CNT_LEN.
  - It clears on reset and on i_clear.
  - It holds in IDLE and HALTED.
- Undefined: o_cycle_count is constant 0 and no counter flops are synthesized.

Test Plan:
- Reset then i_start with i_continuous = 1, no hazards, 5 cycles -> o_pc = 0, 4, 8, 12, 16, 20; o_pipe_en = 1; o_if_flush = 0; o_state = 1.
- RUN at o_pc = 0x10 with i_branch_taken = 1, target 0x40, and i_stall = 1 in the same cycle -> next o_pc = 0x40 and o_if_flush = 1 for that cycle. Then i_jump, target 0x80 -> o_pc = 0x80.
- STEP mode: 3 idle cycles, then i_step pulse, then 2 idle cycles -> o_pc stays 0 during idle, becomes 4 after the step. o_pipe_en is high for exactly 1 cycle.
- RUN, i_halt_instr at o_pc = 0x1C -> o_pc frozen at 0x1C; o_pipe_en high for 4 cycles in DRAIN; then o_halted = 1, o_state = 4. i_clear -> o_state = 0, o_pc = 0.
- i_halt_instr with i_jump (target 0x100) in the same cycle -> o_pc = 0x100, state stays RUN. Separately, i_rst low during the 2nd DRAIN cycle -> o_state = 0, o_pc = 0 immediately, before the next clock edge.
- With PC_SEQ_CYCLE_COUNTER_EN: RUN 10 cycles, then halt drain of 4 -> o_cycle_count = 14 in HALTED; i_clear -> 0. Without the macro -> o_cycle_count = 0 throughout.
